// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: round-robin miss handler for NCH cache channels sharing one
// line-wide memory port. A granted miss writes back a dirty victim, then
// fetches the missing line and strobes it into the requesting cache.
// Note: rst_n is an active-high asynchronous reset despite its name.
module cache_miss_ctrl #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        req_dirty,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*ADDR_W-1:0] req_victim_addr,
  input  logic [NCH*LINE_W-1:0] req_victim_data,
  input  logic [LINE_W-1:0]     mem_rd_data,
  input  logic                  mem_rdy,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     fill_data,
  output logic [NCH-1:0]        fill_we,
  output logic [NCH-1:0]        grant,
  output logic                  freeze
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_reg;         // channel searched first in the next IDLE
  logic [IDX_W-1:0]   gidx_reg;       // index of the channel being served
  logic [ADDR_W-1:0]  miss_addr_reg;  // missing line address latched at grant

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // Reduce (v mod NCH) to a channel index.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NCH);
  endfunction

  // Round-robin pick: first requesting channel at or above rr, wrapping.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(rr_reg) + k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(int'(rr_reg) + k);
      end
    end
  end

  // Stall the pipeline while any miss is pending or being serviced.
  assign freeze = (|req) | (state_reg != IDLE);

  // Miss FSM with registered memory-port and fill outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg     <= IDLE;
      rr_reg        <= '0;
      gidx_reg      <= '0;
      miss_addr_reg <= '0;
      grant         <= '0;
      fill_we       <= '0;
      fill_data     <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            // Operands are captured here so later req_* changes cannot disturb service.
            gidx_reg      <= pick_idx;
            grant         <= NCH'(1) << pick_idx;
            miss_addr_reg <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata     <= req_victim_data[pick_idx*LINE_W +: LINE_W];
            if (req_dirty[pick_idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= req_victim_addr[pick_idx*ADDR_W +: ADDR_W];
              state_reg <= WB;
            end else begin
              mem_re    <= 1'b1;
              mem_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
              state_reg <= FILL;
            end
          end
        end
        WB: begin
          if (mem_rdy) begin
            // Hand straight from write to read with no idle cycle between.
            mem_we    <= 1'b0;
            mem_re    <= 1'b1;
            mem_addr  <= miss_addr_reg;
            state_reg <= FILL;
          end
        end
        FILL: begin
          if (mem_rdy) begin
            mem_re    <= 1'b0;
            fill_data <= mem_rd_data;
            fill_we   <= grant;
            state_reg <= DONE;
          end
        end
        DONE: begin
          fill_we   <= '0;
          grant     <= '0;
          rr_reg    <= wrap_idx(int'(gidx_reg) + 1);
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: a cycle table for the clean and dirty miss
// flows, plus hand sequences for round-robin, reset during WB and NCH=3 wrap.
module tb_cache_miss_ctrl;

  localparam logic [13:0] A0  = 14'h0123;
  localparam logic [13:0] A1  = 14'h1040;
  localparam logic [13:0] VA1 = 14'h0040;
  localparam logic [63:0] VD1 = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] D0  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D1  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DX  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  // NCH=2 instance
  logic [1:0]   req, req_dirty;
  logic [27:0]  req_addr, req_victim_addr;
  logic [127:0] req_victim_data;
  logic [63:0]  mem_rd_data;
  logic         mem_rdy;
  logic [13:0]  mem_addr;
  logic         mem_re, mem_we;
  logic [63:0]  mem_wdata, fill_data;
  logic [1:0]   fill_we, grant;
  logic         freeze;
  // NCH=3 instance
  logic [2:0]   req3, dirty3;
  logic [41:0]  addr3, vaddr3;
  logic [191:0] vdata3;
  logic [63:0]  rd3;
  logic         rdy3;
  logic [13:0]  mem_addr3;
  logic         re3, we3;
  logic [63:0]  wdata3, fdata3;
  logic [2:0]   fwe3, grant3;
  logic         freeze3;

  int checks = 0;
  int errors = 0;

  cache_miss_ctrl #(.NCH(2), .ADDR_W(14), .LINE_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dirty(req_dirty),
    .req_addr(req_addr), .req_victim_addr(req_victim_addr),
    .req_victim_data(req_victim_data), .mem_rd_data(mem_rd_data),
    .mem_rdy(mem_rdy), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .fill_data(fill_data), .fill_we(fill_we),
    .grant(grant), .freeze(freeze)
  );

  cache_miss_ctrl #(.NCH(3), .ADDR_W(14), .LINE_W(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_dirty(dirty3),
    .req_addr(addr3), .req_victim_addr(vaddr3),
    .req_victim_data(vdata3), .mem_rd_data(rd3),
    .mem_rdy(rdy3), .mem_addr(mem_addr3), .mem_re(re3), .mem_we(we3),
    .mem_wdata(wdata3), .fill_data(fdata3), .fill_we(fwe3),
    .grant(grant3), .freeze(freeze3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  dirty;
    logic [13:0] a1;
    logic [13:0] v1;
    logic [63:0] vd1;
    logic [63:0] rd;
    logic        rdy;
    logic        re;
    logic        we;
    logic [13:0] maddr;
    logic [63:0] wdata;
    logic [1:0]  fwe;
    logic [63:0] fdata;
    logic [1:0]  gnt;
    logic        frz;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] dt,
                              input logic [13:0] a1, input logic [13:0] v1,
                              input logic [63:0] vd1, input logic [63:0] rd,
                              input logic rdy, input logic re, input logic we,
                              input logic [13:0] maddr, input logic [63:0] wdata,
                              input logic [1:0] fwe, input logic [63:0] fdata,
                              input logic [1:0] gnt, input logic frz);
    vec_t v;
    v.req = rq; v.dirty = dt; v.a1 = a1; v.v1 = v1; v.vd1 = vd1; v.rd = rd;
    v.rdy = rdy; v.re = re; v.we = we; v.maddr = maddr; v.wdata = wdata;
    v.fwe = fwe; v.fdata = fdata; v.gnt = gnt; v.frz = frz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read and write must never be requested together on either instance.
  always @(negedge clk) begin
    checks++;
    if ((mem_re && mem_we) || (re3 && we3)) begin
      errors++;
      $display("FAIL re_we_exclusive: re=%b we=%b re3=%b we3=%b", mem_re, mem_we, re3, we3);
    end
  end

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    req = '0; req_dirty = '0; req_addr = '0; req_victim_addr = '0;
    req_victim_data = '0; mem_rd_data = '0; mem_rdy = 1'b0;
    req3 = '0; dirty3 = '0; addr3 = '0; vaddr3 = '0; vdata3 = '0; rd3 = '0; rdy3 = 1'b0;

    // Reset state
    tick();
    chk("rst.mem_re", 64'(mem_re), 64'd0);
    chk("rst.mem_we", 64'(mem_we), 64'd0);
    chk("rst.mem_addr", 64'(mem_addr), 64'd0);
    chk("rst.grant", 64'(grant), 64'd0);
    chk("rst.fill_we", 64'(fill_we), 64'd0);
    chk("rst.fill_data", fill_data, 64'd0);
    chk("rst.freeze", 64'(freeze), 64'd0);
    rst_n = 1'b0;
    tick();

    // Clean miss ch0 (rows 0-4), dirty miss ch1 with inputs changed mid-service,
    // then spurious mem_rdy in DONE (row 8) and IDLE (row 9).
    vecs[0] = mk(2'b01, 2'b00, A1, VA1, VD1, 64'd0, 1'b0, 1'b1, 1'b0, A0, 64'd0, 2'b00, 64'd0, 2'b01, 1'b1);
    vecs[1] = mk(2'b01, 2'b00, A1, VA1, VD1, 64'd0, 1'b0, 1'b1, 1'b0, A0, 64'd0, 2'b00, 64'd0, 2'b01, 1'b1);
    vecs[2] = mk(2'b01, 2'b00, A1, VA1, VD1, 64'd0, 1'b0, 1'b1, 1'b0, A0, 64'd0, 2'b00, 64'd0, 2'b01, 1'b1);
    vecs[3] = mk(2'b01, 2'b00, A1, VA1, VD1, D0,    1'b1, 1'b0, 1'b0, A0, 64'd0, 2'b01, D0,    2'b01, 1'b1);
    vecs[4] = mk(2'b00, 2'b00, A1, VA1, VD1, 64'd0, 1'b0, 1'b0, 1'b0, A0, 64'd0, 2'b00, D0,    2'b00, 1'b0);
    vecs[5] = mk(2'b10, 2'b10, A1, VA1, VD1, 64'd0, 1'b0, 1'b0, 1'b1, VA1, VD1,  2'b00, D0,    2'b10, 1'b1);
    vecs[6] = mk(2'b10, 2'b10, 14'h3FFF, 14'h1111, 64'd5, 64'd0, 1'b1, 1'b1, 1'b0, A1, VD1, 2'b00, D0, 2'b10, 1'b1);
    vecs[7] = mk(2'b10, 2'b10, 14'h3FFF, 14'h1111, 64'd5, D1,    1'b1, 1'b0, 1'b0, A1, VD1, 2'b10, D1, 2'b10, 1'b1);
    vecs[8] = mk(2'b00, 2'b00, A1, VA1, VD1, DX,    1'b1, 1'b0, 1'b0, A1, VD1, 2'b00, D1, 2'b00, 1'b0);
    vecs[9] = mk(2'b00, 2'b00, A1, VA1, VD1, DX,    1'b1, 1'b0, 1'b0, A1, VD1, 2'b00, D1, 2'b00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      req             = vecs[i].req;
      req_dirty       = vecs[i].dirty;
      req_addr        = {vecs[i].a1, A0};
      req_victim_addr = {vecs[i].v1, 14'h0000};
      req_victim_data = {vecs[i].vd1, 64'd0};
      mem_rd_data     = vecs[i].rd;
      mem_rdy         = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d.mem_re", i), 64'(mem_re), 64'(vecs[i].re));
      chk($sformatf("vec%0d.mem_we", i), 64'(mem_we), 64'(vecs[i].we));
      chk($sformatf("vec%0d.mem_addr", i), 64'(mem_addr), 64'(vecs[i].maddr));
      chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].wdata);
      chk($sformatf("vec%0d.fill_we", i), 64'(fill_we), 64'(vecs[i].fwe));
      chk($sformatf("vec%0d.fill_data", i), fill_data, vecs[i].fdata);
      chk($sformatf("vec%0d.grant", i), 64'(grant), 64'(vecs[i].gnt));
      chk($sformatf("vec%0d.freeze", i), 64'(freeze), 64'(vecs[i].frz));
      $display("vec %0d req=%b rdy=%b -> re=%b we=%b addr=%h fill_we=%b grant=%b",
               i, vecs[i].req, vecs[i].rdy, mem_re, mem_we, mem_addr, fill_we, grant);
    end
    mem_rdy = 1'b0;

    // Both channels requesting continuously from reset: grants alternate 0,1,0,1.
    do_reset();
    req = 2'b11; req_dirty = 2'b00; req_addr = {14'h0200, 14'h0100};
    for (int i = 0; i < 4; i++) begin
      logic [1:0] eg;
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk($sformatf("rr%0d.grant", i), 64'(grant), 64'(eg));
      chk($sformatf("rr%0d.mem_addr", i), 64'(mem_addr), (i % 2 == 0) ? 64'h0100 : 64'h0200);
      mem_rdy = 1'b1; mem_rd_data = 64'(i + 16);
      tick();
      chk($sformatf("rr%0d.fill_we", i), 64'(fill_we), 64'(eg));
      chk($sformatf("rr%0d.fill_data", i), fill_data, 64'(i + 16));
      mem_rdy = 1'b0;
      tick();
      chk($sformatf("rr%0d.idle_grant", i), 64'(grant), 64'd0);
      $display("rr %0d grant=%b fill_data=%h", i, eg, fill_data);
    end
    req = 2'b00;
    tick();

    // Reset asserted during WB abandons the write-back; ch1 served after release.
    req = 2'b10; req_dirty = 2'b10; req_victim_addr = {14'h0055, 14'h0000};
    req_victim_data = {64'h77, 64'd0}; req_addr = {14'h0255, 14'h0000};
    tick();
    chk("rstwb.pre_we", 64'(mem_we), 64'd1);
    chk("rstwb.pre_grant", 64'(grant), 64'b10);
    rst_n = 1'b1;
    #1;
    chk("rstwb.mem_we", 64'(mem_we), 64'd0);
    chk("rstwb.mem_re", 64'(mem_re), 64'd0);
    chk("rstwb.grant", 64'(grant), 64'd0);
    chk("rstwb.fill_we", 64'(fill_we), 64'd0);
    chk("rstwb.mem_addr", 64'(mem_addr), 64'd0);
    chk("rstwb.mem_wdata", mem_wdata, 64'd0);
    chk("rstwb.fill_data", fill_data, 64'd0);
    chk("rstwb.freeze", 64'(freeze), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstwb.post_grant", 64'(grant), 64'b10);
    chk("rstwb.post_we", 64'(mem_we), 64'd1);
    chk("rstwb.post_addr", 64'(mem_addr), 64'h0055);
    mem_rdy = 1'b1; mem_rd_data = 64'h99;
    tick();
    chk("rstwb.fill_addr", 64'(mem_addr), 64'h0255);
    tick();
    chk("rstwb.fill_we", 64'(fill_we), 64'b10);
    chk("rstwb.fill_data2", fill_data, 64'h99);
    mem_rdy = 1'b0; req = 2'b00;
    tick();
    $display("rstwb served ch1 fill_data=%h", fill_data);

    // NCH=3: ch1 completes (rr -> 2), then req=101 gives ch2 then ch0.
    addr3 = {14'h0300, 14'h0200, 14'h0100};
    req3 = 3'b010;
    tick();
    chk("n3.first_grant", 64'(grant3), 64'b010);
    rdy3 = 1'b1; rd3 = 64'h1;
    tick();
    chk("n3.first_fill", 64'(fwe3), 64'b010);
    rdy3 = 1'b0; req3 = 3'b101;
    tick();
    tick();
    chk("n3.wrap_grant2", 64'(grant3), 64'b100);
    chk("n3.wrap_addr2", 64'(mem_addr3), 64'h0300);
    rdy3 = 1'b1; rd3 = 64'h2;
    tick();
    chk("n3.fill2", 64'(fwe3), 64'b100);
    rdy3 = 1'b0;
    tick();
    tick();
    chk("n3.wrap_grant0", 64'(grant3), 64'b001);
    chk("n3.wrap_addr0", 64'(mem_addr3), 64'h0100);
    rdy3 = 1'b1; rd3 = 64'h3;
    tick();
    chk("n3.fill0", 64'(fwe3), 64'b001);
    chk("n3.fill0_data", fdata3, 64'h3);
    rdy3 = 1'b0; req3 = 3'b000;
    tick();
    $display("nch3 wrap sequence ch1 -> ch2 -> ch0 grant=%b", grant3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Parametrised miss handler arbitrating NCH cache channels (channel 0 = icache, channel 1 = dcache by default) onto one unified memory port. Per granted miss it writes back a dirty victim line, then fetches the missing line and returns it to the requesting cache. Arbitration is round-robin; freeze is asserted while any miss is outstanding. It sits between the caches and `unified_mem`, as the successor to the fixed two-cache controller.

## Interface
- NCH, 2: number of cache channels (≥2)
- ADDR_W, 14: line address width
- LINE_W, 64: line width in bits
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-high: asserted when 1, despite the name
- req  in  NCH  per-channel miss pending (level, held by cache until its fill_we)
- req_dirty  in  NCH  victim line of that channel is dirty
- req_addr  in  NCH*ADDR_W  missing line address, channel i at [i*ADDR_W +: ADDR_W]
- req_victim_addr  in  NCH*ADDR_W  victim line address, same packing
- req_victim_data  in  NCH*LINE_W  victim line data, channel i at [i*LINE_W +: LINE_W]
- mem_rd_data  in  LINE_W  memory read data, valid with mem_rdy
- mem_rdy  in  1  memory completion pulse for current re/we
- mem_addr  out  ADDR_W  memory line address
- mem_re  out  1  memory read request
- mem_we  out  1  memory write request
- mem_wdata  out  LINE_W  memory write data
- fill_data  out  LINE_W  line returned to caches
- fill_we  out  NCH  one-hot, one-cycle write strobe to the granted cache
- grant  out  NCH  one-hot channel currently being served, 0 in IDLE
- freeze  out  1  pipeline stall

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: if any req bit set, choose first set bit searching upward from rr pointer, wrapping mod NCH. Latch grant, req_addr, victim addr/data, dirty bit of that channel. Next state WB if dirty, else FILL. No req: stay.
- WB: mem_we=1, mem_addr=latched victim addr, mem_wdata=latched victim data. On mem_rdy -> FILL.
- FILL: mem_re=1, mem_addr=latched req_addr. On mem_rdy: fill_data <= mem_rd_data, fill_we[g] <= 1, -> DONE.
- DONE: fill_we deasserts (strobe lasted exactly one cycle, the DONE cycle); rr <= (g+1) mod NCH; grant cleared; -> IDLE.
- mem_re and mem_we never both 1; both 0 in IDLE and DONE.
- mem_rdy ignored in IDLE and DONE.
- Operands are latched at grant: changes on req_* inputs during WB/FILL have no effect; a req dropped mid-service still completes, including fill_we.
- freeze = (|req) | (state != IDLE), combinational.
- Channels not granted wait; their req is sampled again only in IDLE.

## Timing
- Reset (async, rst_n=1): state IDLE, rr=0, grant=0, fill_we=0, fill_data=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0; freeze follows req only.
- Clean miss: req sampled at edge E0 -> FILL from E0; mem_rdy sampled at edge Ek -> fill_we high during cycle Ek..Ek+1 (DONE); IDLE at Ek+1. Back-to-back request served from IDLE sampled at Ek+1, so the next grant is visible from Ek+2.
- Dirty miss adds the WB phase: FILL starts the edge mem_rdy is sampled in WB; memory sees a single-cycle gap-free transition from we to re.
- mem_rdy arriving the first cycle of WB/FILL is accepted (minimum phase length 1 cycle).
- Reset mid-transaction: abandon immediately, no fill_we, rr back to 0.
- Cache must deassert req (or present the next miss) by the IDLE cycle following fill_we; a still-high req is treated as a new miss.

## Test plan
- Clean miss ch0, addr 0x0123, memory returns 0xDEAD_BEEF_0000_0001 after 3 cycles -> mem_re only, mem_addr=0x0123, fill_we=01 for one cycle with that data, freeze low after req drops.
- Dirty miss ch1, victim 0x0040/data 0xAAAA…AA, miss 0x1040 -> mem_we with 0x0040/0xAAAA…AA, then mem_re 0x1040, fill_we=10; no cycle with re and we both high.
- req=11 simultaneously from reset -> ch0 served first, then ch1; with ch0 req re-asserted continuously and ch1 too, grants alternate 0,1,0,1.
- Spurious mem_rdy in IDLE and DONE -> no state change, no fill_we.
- rst_n asserted during WB -> all outputs 0 next instant, no fill_we; after release, pending req=10 served as ch1.
- NCH=3, rr at 2 after ch1 completion, req=101 -> ch2 then ch0 (wrap).
